// File: rtl/veggie_port_arbiter.sv
// Round-robin operand-read sequencer for the banked vector register file.
// Writeback always wins its bank; same-bank two-row reads are split over two cycles.
module veggie_port_arbiter #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_BANKS = 4,
    parameter int REG_W     = 5,
    parameter int RD_LAT    = 1,
    localparam int BANK_W   = $clog2(NUM_BANKS),
    localparam int ROW_W    = REG_W - BANK_W,
    localparam int ID_W     = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                       CLK,
    input  logic                       nRST,
    input  logic [NUM_REQ-1:0]         req_valid,
    output logic [NUM_REQ-1:0]         req_ready,
    input  logic [NUM_REQ-1:0]         req_two,
    input  logic [NUM_REQ*REG_W-1:0]   req_vs1,
    input  logic [NUM_REQ*REG_W-1:0]   req_vs2,
    input  logic                       wb_valid,
    input  logic [REG_W-1:0]           wb_vd,
    output logic                       wb_ready,
    output logic [NUM_BANKS-1:0]       bank_ren,
    output logic [NUM_BANKS-1:0]       bank_wen,
    output logic [NUM_BANKS*ROW_W-1:0] bank_raddr,
    output logic [NUM_BANKS*ROW_W-1:0] bank_waddr,
    output logic                       rsp1_valid,
    output logic                       rsp2_valid,
    output logic [BANK_W-1:0]          rsp1_bank,
    output logic [BANK_W-1:0]          rsp2_bank,
    output logic [ID_W-1:0]            rsp_id,
    output logic [0:0]                 dbg_state,
    output logic [ID_W-1:0]            dbg_ptr
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SPLIT = 1'b1;

    // Handshake: a request is held with valid until the cycle req_ready is high;
    // wb_ready is the same-cycle acceptance of a pending writeback.

    logic [0:0]        state, nxt_state;
    logic [ID_W-1:0]   ptr, nxt_ptr, win, lat_id;
    logic [ROW_W-1:0]  lat_row;
    logic [BANK_W-1:0] lat_bank;
    logic              found, latch_en, wb_act;
    logic [BANK_W-1:0] wb_bank, b1, b2;
    logic [ROW_W-1:0]  wb_row, r1, r2;
    logic [REG_W-1:0]  v1, v2;
    logic              two, need2;

    logic              iss_v1, iss_v2;
    logic [BANK_W-1:0] iss_b1, iss_b2;
    logic [ID_W-1:0]   iss_id;

    logic              pipe_v1 [RD_LAT];
    logic              pipe_v2 [RD_LAT];
    logic [BANK_W-1:0] pipe_b1 [RD_LAT];
    logic [BANK_W-1:0] pipe_b2 [RD_LAT];
    logic [ID_W-1:0]   pipe_id [RD_LAT];

    function automatic logic [ID_W-1:0] next_id(input logic [ID_W-1:0] id);
        return (id == ID_W'(NUM_REQ - 1)) ? '0 : id + ID_W'(1);
    endfunction

    always_comb begin
        found = 1'b0;
        win   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req_valid[(int'(ptr) + k) % NUM_REQ]) begin
                found = 1'b1;
                win   = ID_W'((int'(ptr) + k) % NUM_REQ);
            end
        end
    end

    always_comb begin
        wb_act  = wb_valid & ~nRST;
        wb_bank = wb_vd[BANK_W-1:0];
        wb_row  = wb_vd[REG_W-1:BANK_W];
        v1      = req_vs1[int'(win)*REG_W +: REG_W];
        v2      = req_vs2[int'(win)*REG_W +: REG_W];
        two     = req_two[win];
        b1      = v1[BANK_W-1:0];
        r1      = v1[REG_W-1:BANK_W];
        b2      = v2[BANK_W-1:0];
        r2      = v2[REG_W-1:BANK_W];
        need2   = two && (v1 != v2);

        req_ready  = '0;
        wb_ready   = wb_act;
        bank_ren   = '0;
        bank_wen   = '0;
        bank_raddr = '0;
        bank_waddr = '0;
        nxt_state  = state;
        nxt_ptr    = ptr;
        latch_en   = 1'b0;
        iss_v1     = 1'b0;
        iss_v2     = 1'b0;
        iss_b1     = '0;
        iss_b2     = '0;
        iss_id     = '0;

        if (wb_act) begin
            bank_wen[wb_bank] = 1'b1;
            bank_waddr[int'(wb_bank)*ROW_W +: ROW_W] = wb_row;
        end

        if (!nRST) begin
            case (state)
                IDLE: begin
                    if (found && (!need2 || b1 != b2)) begin
                        if (!(wb_act && (b1 == wb_bank || (need2 && b2 == wb_bank)))) begin
                            bank_ren[b1] = 1'b1;
                            bank_raddr[int'(b1)*ROW_W +: ROW_W] = r1;
                            if (need2) begin
                                bank_ren[b2] = 1'b1;
                                bank_raddr[int'(b2)*ROW_W +: ROW_W] = r2;
                            end
                            req_ready[win] = 1'b1;
                            nxt_ptr = next_id(win);
                            iss_v1  = 1'b1;
                            iss_v2  = two;
                            iss_b1  = b1;
                            iss_b2  = two ? b2 : '0;
                            iss_id  = win;
                        end
                    end else if (found) begin
                        // Same bank, different rows: first half now, vs2 from SPLIT.
                        if (!(wb_act && b1 == wb_bank)) begin
                            bank_ren[b1] = 1'b1;
                            bank_raddr[int'(b1)*ROW_W +: ROW_W] = r1;
                            latch_en  = 1'b1;
                            nxt_state = SPLIT;
                            iss_v1    = 1'b1;
                            iss_b1    = b1;
                            iss_id    = win;
                        end
                    end
                end
                default: begin
                    if (!(wb_act && lat_bank == wb_bank)) begin
                        bank_ren[lat_bank] = 1'b1;
                        bank_raddr[int'(lat_bank)*ROW_W +: ROW_W] = lat_row;
                        req_ready[lat_id] = 1'b1;
                        nxt_ptr   = next_id(lat_id);
                        nxt_state = IDLE;
                        iss_v2    = 1'b1;
                        iss_b2    = lat_bank;
                        iss_id    = lat_id;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (nRST) begin
            state    <= IDLE;
            ptr      <= '0;
            lat_id   <= '0;
            lat_row  <= '0;
            lat_bank <= '0;
            for (int i = 0; i < RD_LAT; i++) begin
                pipe_v1[i] <= 1'b0;
                pipe_v2[i] <= 1'b0;
                pipe_b1[i] <= '0;
                pipe_b2[i] <= '0;
                pipe_id[i] <= '0;
            end
        end else begin
            state <= nxt_state;
            ptr   <= nxt_ptr;
            if (latch_en) begin
                lat_id   <= win;
                lat_row  <= r2;
                lat_bank <= b2;
            end
            pipe_v1[0] <= iss_v1;
            pipe_v2[0] <= iss_v2;
            pipe_b1[0] <= iss_b1;
            pipe_b2[0] <= iss_b2;
            pipe_id[0] <= iss_id;
            for (int i = RD_LAT - 1; i > 0; i--) begin
                pipe_v1[i] <= pipe_v1[i-1];
                pipe_v2[i] <= pipe_v2[i-1];
                pipe_b1[i] <= pipe_b1[i-1];
                pipe_b2[i] <= pipe_b2[i-1];
                pipe_id[i] <= pipe_id[i-1];
            end
        end
    end

    assign rsp1_valid = pipe_v1[RD_LAT-1] & ~nRST;
    assign rsp2_valid = pipe_v2[RD_LAT-1] & ~nRST;
    assign rsp1_bank  = nRST ? '0 : pipe_b1[RD_LAT-1];
    assign rsp2_bank  = nRST ? '0 : pipe_b2[RD_LAT-1];
    assign rsp_id     = nRST ? '0 : pipe_id[RD_LAT-1];
    assign dbg_state  = state;
    assign dbg_ptr    = ptr;
endmodule

// File: tb/tb_veggie_port_arbiter.sv
// Directed table-driven bench for veggie_port_arbiter (default parameters),
// plus a hand-written reset-during-SPLIT sequence.
module tb_veggie_port_arbiter;
    logic        CLK = 1'b0;
    logic        nRST;
    logic [3:0]  req_valid, req_ready, req_two;
    logic [19:0] req_vs1, req_vs2;
    logic        wb_valid, wb_ready;
    logic [4:0]  wb_vd;
    logic [3:0]  bank_ren, bank_wen;
    logic [11:0] bank_raddr, bank_waddr;
    logic        rsp1_valid, rsp2_valid;
    logic [1:0]  rsp1_bank, rsp2_bank, rsp_id, dbg_ptr;
    logic [0:0]  dbg_state;

    int total = 0;
    int passed = 0;

    veggie_port_arbiter dut (
        .CLK(CLK), .nRST(nRST),
        .req_valid(req_valid), .req_ready(req_ready), .req_two(req_two),
        .req_vs1(req_vs1), .req_vs2(req_vs2),
        .wb_valid(wb_valid), .wb_vd(wb_vd), .wb_ready(wb_ready),
        .bank_ren(bank_ren), .bank_wen(bank_wen),
        .bank_raddr(bank_raddr), .bank_waddr(bank_waddr),
        .rsp1_valid(rsp1_valid), .rsp2_valid(rsp2_valid),
        .rsp1_bank(rsp1_bank), .rsp2_bank(rsp2_bank), .rsp_id(rsp_id),
        .dbg_state(dbg_state), .dbg_ptr(dbg_ptr)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        rst;
        logic [3:0]  valid;
        logic [3:0]  two;
        logic [19:0] vs1;
        logic [19:0] vs2;
        logic        wbv;
        logic [4:0]  wbd;
        logic [3:0]  ready;
        logic        wbr;
        logic [3:0]  ren;
        logic [3:0]  wen;
        logic [11:0] raddr;
        logic [11:0] waddr;
        logic        r1v;
        logic        r2v;
        logic [1:0]  r1b;
        logic [1:0]  r2b;
        logic [1:0]  rid;
        logic [1:0]  ptr;
    } vec_t;

    vec_t vec_q[$];

    function automatic logic [19:0] rv(input int a0, input int a1, input int a2, input int a3);
        return {5'(a3), 5'(a2), 5'(a1), 5'(a0)};
    endfunction

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp)
            $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
        else
            passed++;
    endtask

    task automatic drive(input logic rst, input logic [3:0] v, input logic [3:0] t,
                         input logic [19:0] a, input logic [19:0] b,
                         input logic wv, input logic [4:0] wd);
        nRST = rst; req_valid = v; req_two = t; req_vs1 = a; req_vs2 = b;
        wb_valid = wv; wb_vd = wd;
    endtask

    initial begin
        #100000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        // rst valid two vs1 vs2 wbv wbd | ready wbr ren wen raddr waddr r1v r2v r1b r2b rid ptr
        vec_q.push_back('{0,4'b0001,4'b0001,rv(2,0,0,0),rv(5,0,0,0),0,5'd0, 4'b0001,0,4'b0110,4'b0000,12'h008,12'h000,0,0,2'd0,2'd0,2'd0,2'd0});
        vec_q.push_back('{0,4'b1111,4'b0000,rv(4,5,10,15),rv(0,0,0,0),0,5'd0, 4'b0010,0,4'b0010,4'b0000,12'h008,12'h000,1,1,2'd2,2'd1,2'd0,2'd1});
        vec_q.push_back('{0,4'b1111,4'b0000,rv(4,5,10,15),rv(0,0,0,0),0,5'd0, 4'b0100,0,4'b0100,4'b0000,12'h080,12'h000,1,0,2'd1,2'd0,2'd1,2'd2});
        vec_q.push_back('{0,4'b1111,4'b0000,rv(4,5,10,15),rv(0,0,0,0),0,5'd0, 4'b1000,0,4'b1000,4'b0000,12'h600,12'h000,1,0,2'd2,2'd0,2'd2,2'd3});
        vec_q.push_back('{0,4'b1111,4'b0000,rv(4,5,10,15),rv(0,0,0,0),0,5'd0, 4'b0001,0,4'b0001,4'b0000,12'h001,12'h000,1,0,2'd3,2'd0,2'd3,2'd0});
        vec_q.push_back('{0,4'b0010,4'b0010,rv(0,3,0,0),rv(0,7,0,0),0,5'd0, 4'b0000,0,4'b1000,4'b0000,12'h000,12'h000,1,0,2'd0,2'd0,2'd0,2'd1});
        vec_q.push_back('{0,4'b0010,4'b0010,rv(0,3,0,0),rv(0,7,0,0),0,5'd0, 4'b0010,0,4'b1000,4'b0000,12'h200,12'h000,1,0,2'd3,2'd0,2'd1,2'd1});
        vec_q.push_back('{0,4'b0001,4'b0000,rv(2,0,0,0),rv(0,0,0,0),1,5'd6, 4'b0000,1,4'b0000,4'b0100,12'h000,12'h040,0,1,2'd0,2'd3,2'd1,2'd2});
        vec_q.push_back('{0,4'b0001,4'b0000,rv(2,0,0,0),rv(0,0,0,0),0,5'd0, 4'b0001,0,4'b0100,4'b0000,12'h000,12'h000,0,0,2'd0,2'd0,2'd0,2'd2});
        vec_q.push_back('{0,4'b0001,4'b0001,rv(9,0,0,0),rv(9,0,0,0),0,5'd0, 4'b0001,0,4'b0010,4'b0000,12'h010,12'h000,1,0,2'd2,2'd0,2'd0,2'd1});
        vec_q.push_back('{0,4'b0000,4'b0000,rv(0,0,0,0),rv(0,0,0,0),0,5'd0, 4'b0000,0,4'b0000,4'b0000,12'h000,12'h000,1,1,2'd1,2'd1,2'd0,2'd1});
        vec_q.push_back('{0,4'b0100,4'b0100,rv(0,0,0,0),rv(0,0,13,0),1,5'd5, 4'b0000,1,4'b0000,4'b0010,12'h000,12'h008,0,0,2'd0,2'd0,2'd0,2'd1});
        vec_q.push_back('{0,4'b0100,4'b0100,rv(0,0,0,0),rv(0,0,13,0),0,5'd0, 4'b0100,0,4'b0011,4'b0000,12'h018,12'h000,0,0,2'd0,2'd0,2'd0,2'd1});
        vec_q.push_back('{0,4'b0000,4'b0000,rv(0,0,0,0),rv(0,0,0,0),0,5'd0, 4'b0000,0,4'b0000,4'b0000,12'h000,12'h000,1,1,2'd0,2'd1,2'd2,2'd3});
        vec_q.push_back('{0,4'b1001,4'b0000,rv(4,0,0,2),rv(0,0,0,0),1,5'd6, 4'b0000,1,4'b0000,4'b0100,12'h000,12'h040,0,0,2'd0,2'd0,2'd0,2'd3});
        vec_q.push_back('{0,4'b1001,4'b0000,rv(4,0,0,2),rv(0,0,0,0),0,5'd0, 4'b1000,0,4'b0100,4'b0000,12'h000,12'h000,0,0,2'd0,2'd0,2'd0,2'd3});
        vec_q.push_back('{0,4'b0001,4'b0000,rv(4,0,0,2),rv(0,0,0,0),0,5'd0, 4'b0001,0,4'b0001,4'b0000,12'h001,12'h000,1,0,2'd2,2'd0,2'd3,2'd0});
        vec_q.push_back('{0,4'b0000,4'b0000,rv(0,0,0,0),rv(0,0,0,0),0,5'd0, 4'b0000,0,4'b0000,4'b0000,12'h000,12'h000,1,0,2'd0,2'd0,2'd0,2'd1});

        // Reset with a request and writeback pending: everything gated off.
        drive(1, 4'b0001, 4'b0001, rv(2,0,0,0), rv(5,0,0,0), 1, 5'd6);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("rst_ready", -1, req_ready, 4'b0000);
        chk("rst_wb_ready", -1, wb_ready, 1'b0);
        chk("rst_ren", -1, bank_ren, 4'b0000);
        chk("rst_wen", -1, bank_wen, 4'b0000);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("rst_ptr", -1, dbg_ptr, 2'd0);
        chk("rst_state", -1, dbg_state, 1'b0);
        chk("rst_rsp1", -1, rsp1_valid, 1'b0);

        for (int i = 0; i < vec_q.size(); i++) begin
            @(posedge CLK); #1;
            drive(vec_q[i].rst, vec_q[i].valid, vec_q[i].two, vec_q[i].vs1, vec_q[i].vs2,
                  vec_q[i].wbv, vec_q[i].wbd);
            @(negedge CLK);
            chk("req_ready", i, req_ready, vec_q[i].ready);
            chk("wb_ready", i, wb_ready, vec_q[i].wbr);
            chk("bank_ren", i, bank_ren, vec_q[i].ren);
            chk("bank_wen", i, bank_wen, vec_q[i].wen);
            chk("bank_raddr", i, bank_raddr, vec_q[i].raddr);
            chk("bank_waddr", i, bank_waddr, vec_q[i].waddr);
            chk("rsp1_valid", i, rsp1_valid, vec_q[i].r1v);
            chk("rsp2_valid", i, rsp2_valid, vec_q[i].r2v);
            chk("rsp1_bank", i, rsp1_bank, vec_q[i].r1b);
            chk("rsp2_bank", i, rsp2_bank, vec_q[i].r2b);
            chk("rsp_id", i, rsp_id, vec_q[i].rid);
            chk("ptr", i, dbg_ptr, vec_q[i].ptr);
        end

        // Reset in the middle of a split: the issued first half must never respond.
        @(posedge CLK); #1;
        drive(0, 4'b0010, 4'b0010, rv(0,3,0,0), rv(0,7,0,0), 0, 5'd0);
        @(negedge CLK);
        chk("split_enter_ren", 100, bank_ren, 4'b1000);
        chk("split_enter_ready", 100, req_ready, 4'b0000);
        @(posedge CLK); #1;
        chk("split_state", 101, dbg_state, 1'b1);
        drive(1, 4'b0010, 4'b0010, rv(0,3,0,0), rv(0,7,0,0), 1, 5'd6);
        @(negedge CLK);
        chk("split_rst_ren", 101, bank_ren, 4'b0000);
        chk("split_rst_ready", 101, req_ready, 4'b0000);
        chk("split_rst_wb_ready", 101, wb_ready, 1'b0);
        chk("split_rst_rsp1", 101, rsp1_valid, 1'b0);
        @(posedge CLK); #1;
        drive(0, 4'b0000, 4'b0000, rv(0,0,0,0), rv(0,0,0,0), 0, 5'd0);
        @(negedge CLK);
        chk("post_rst_rsp1", 102, rsp1_valid, 1'b0);
        chk("post_rst_rsp2", 102, rsp2_valid, 1'b0);
        chk("post_rst_ptr", 102, dbg_ptr, 2'd0);
        chk("post_rst_state", 102, dbg_state, 1'b0);
        @(posedge CLK); #1;
        @(negedge CLK);
        chk("post_rst_rsp2_late", 103, rsp2_valid, 1'b0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule

// File: doc/veggie_port_arbiter.md
# veggie_port_arbiter

Sequencer and round-robin arbiter for the banked vector register file (veggie). Accepts operand-read requests from NUM_REQ functional-unit requesters plus one writeback stream, maps register indices to banks, issues per-bank read/write enables without bank conflicts, and returns tagged response strobes telling the datapath which bank output carries each operand. Sits between the issue/scoreboard stage and the veggie bank array.

## Interface
- NUM_REQ, 4, number of read requesters
- NUM_BANKS, 4, veggie banks (power of 2); BANK_W = log2(NUM_BANKS)
- REG_W, 5, vector register index width; ROW_W = REG_W - BANK_W
- RD_LAT, 1, bank read latency in cycles (>=1)

- CLK  in  1  clock, all state on rising edge
- nRST  in  1  synchronous, active-high reset (1 = reset)
- req_valid  in  NUM_REQ  request pending per requester
- req_ready  out  NUM_REQ  request completes this cycle
- req_two  in  NUM_REQ  request needs second operand vs2
- req_vs1, req_vs2  in  NUM_REQ*REG_W  source register indices
- wb_valid  in  1  writeback pending; wb_vd  in  REG_W  destination
- wb_ready  out  1  writeback accepted
- bank_ren, bank_wen  out  NUM_BANKS  per-bank read/write enable
- bank_raddr, bank_waddr  out  NUM_BANKS*ROW_W  per-bank row
- rsp1_valid, rsp2_valid  out  1  operand 1 / operand 2 data valid on banks
- rsp1_bank, rsp2_bank  out  BANK_W  bank carrying operand 1 / 2
- rsp_id  out  log2(NUM_REQ)  requester owning the response

## Operation
- Bank = index[BANK_W-1:0]; row = index[REG_W-1:BANK_W].
- Writeback has absolute priority: wb_ready = wb_valid & ~nRST; when accepted, bank_wen[wb bank]=1, bank_waddr = wb row. That bank is unavailable for reads this cycle.
- Round-robin pointer ptr (reset 0). Winner = first requester with req_valid set, scanning ptr, ptr+1, … mod NUM_REQ. Only the winner is considered; if it cannot proceed, no read issues (no skipping to others).
- FSM IDLE:
  - Winner single-operand, or vs1==vs2, or banks differ: issue all needed reads if none hits the write bank; assert req_ready[winner]; ptr <= winner+1. Otherwise stall, ptr unchanged.
  - Two operands, same bank, different rows: read vs1 (if bank free), latch winner id/vs2, go SPLIT; req_ready not asserted.
- FSM SPLIT: read latched vs2 when its bank is free of writes; then assert req_ready[id], ptr <= id+1, go IDLE. Other requesters ignored while in SPLIT.
- Requester must hold valid/vs1/vs2/two stable until req_ready; violation is undefined.
- Response pipeline: RD_LAT-deep shift register of {v1, v2, bank1, bank2, id}; entry captured on each issue cycle. vs1==vs2 ⇒ one bank read, rsp1 and rsp2 both asserted with same bank. Single-operand ⇒ rsp2_valid=0. SPLIT ⇒ rsp1 and rsp2 emerge in different cycles with same rsp_id.
- Disabled bank addresses drive 0.

## Timing
- Reset: all outputs 0, FSM IDLE, ptr 0, response pipeline cleared; reset mid-SPLIT abandons the request (no response emitted for reads issued in the previous RD_LAT cycles).
- req_ready, wb_ready, bank_* combinational from current inputs and state (same cycle).
- rsp*_valid asserted exactly RD_LAT cycles after matching bank_ren.
- Throughput: one non-split request per cycle; split request takes ≥2 cycles.
- Simultaneous writeback and conflicting read: write proceeds, read retries next cycle.

## Test plan
- Reset then req_valid=0001, vs1=2, vs2=5, two=1 -> cycle 0: bank_ren=0110, raddr bank2=0, bank1=1, req_ready=0001; cycle 1: rsp1 bank2, rsp2 bank1, id 0.
- req_valid=1111 held, non-conflicting regs -> grants 0,1,2,3,0 in consecutive cycles.
- Requester 1, vs1=3, vs2=7 (both bank 3) -> SPLIT: cycle 0 row0 read, cycle 1 row1 read + req_ready=0010; rsp1 at cycle 1, rsp2 at cycle 2, id 1.
- wb_vd=6 with request vs1=2 -> bank_wen=0100 row1, no read, ptr held; next cycle read issues.
- vs1=vs2=9 -> single read bank1 row2, rsp1 and rsp2 both valid, both bank 1.
- nRST asserted during SPLIT -> next cycle all outputs 0, ptr 0, no responses.
